// File: rtl/ipg_pkg.sv
// Shared IPG definitions: block-type codes and the
// reply-buffer write FSM encoding.
package ipg_pkg;

  localparam logic [7:0] BT_REQFIRST  = 8'h0a;
  localparam logic [7:0] BT_REQ       = 8'h1a;
  localparam logic [7:0] BT_REQLAST   = 8'h2a;
  localparam logic [7:0] BT_RESPFIRST = 8'h0b;
  localparam logic [7:0] BT_RRESP     = 8'h1b;
  localparam logic [7:0] BT_RESPLAST  = 8'h2b;
  localparam logic [7:0] BT_CTLFIRST  = 8'h0c;
  localparam logic [7:0] BT_CTL       = 8'h1c;
  localparam logic [7:0] BT_CTLLAST   = 8'h2c;

  localparam logic [1:0] WR_IDLE    = 2'd0;
  localparam logic [1:0] WR_OPEN    = 2'd1;
  localparam logic [1:0] WR_DISCARD = 2'd2;

endpackage

// File: rtl/ipg_chunk_ram.sv
// Simple dual-port register array: one synchronous
// write port, one asynchronous read port.
module ipg_chunk_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ipg_resp_tx_buf.sv
// Store-and-forward reply buffer: only whole, well-formed
// response messages are released to the TX IPG inserter.
module ipg_resp_tx_buf
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memq_write,
  input  logic [DATA_WIDTH-1:0] ipg_reply_chunk,
  input  logic                  tx_ipg_ready,
  output logic                  tx_ipg_valid,
  output logic [DATA_WIDTH-1:0] tx_ipg_data,
  output logic [PW-1:0]         msg_count,
  output logic [PW-1:0]         fifo_level,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    st;

  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] cm_nxt;
  logic [1:0]    st_nxt;
  logic          we;
  logic [AW-1:0] waddr;
  logic          drop_inc;
  logic          commit_ev;

  logic [7:0] in_type;
  logic       is_first;
  logic       is_mid;
  logic       is_last;
  logic       full;
  logic       pop;
  logic       pop_last;

  assign in_type  = ipg_reply_chunk[7:0];
  assign is_first = (in_type == BT_RESPFIRST);
  assign is_mid   = (in_type == BT_RRESP);
  assign is_last  = (in_type == BT_RESPLAST);
  assign full     = ((wr_ptr - rd_ptr) == PW'(DEPTH));

  assign tx_ipg_valid = (rd_ptr != commit_ptr);
  assign pop          = tx_ipg_valid & tx_ipg_ready;
  assign pop_last     = pop && (tx_ipg_data[7:0] == BT_RESPLAST);
  assign fifo_level   = wr_ptr - rd_ptr;

  always_comb begin
    we        = 1'b0;
    waddr     = wr_ptr[AW-1:0];
    wr_nxt    = wr_ptr;
    cm_nxt    = commit_ptr;
    st_nxt    = st;
    drop_inc  = 1'b0;
    commit_ev = 1'b0;
    if (memq_write) begin
      unique case (st)
        WR_IDLE: begin
          unique case (1'b1)
            is_first: begin
              we     = 1'b1;
              wr_nxt = wr_ptr + PW'(1);
              st_nxt = WR_OPEN;
            end
            is_last: begin
              we        = 1'b1;
              wr_nxt    = wr_ptr + PW'(1);
              cm_nxt    = wr_ptr + PW'(1);
              commit_ev = 1'b1;
            end
            default: begin
              st_nxt   = WR_DISCARD;
              drop_inc = 1'b1;
            end
          endcase
        end
        WR_OPEN: begin
          unique case (1'b1)
            is_mid: begin
              we     = 1'b1;
              wr_nxt = wr_ptr + PW'(1);
            end
            is_last: begin
              we        = 1'b1;
              wr_nxt    = wr_ptr + PW'(1);
              cm_nxt    = wr_ptr + PW'(1);
              commit_ev = 1'b1;
              st_nxt    = WR_IDLE;
            end
            is_first: begin
              // restart the open message in place
              we       = 1'b1;
              waddr    = commit_ptr[AW-1:0];
              wr_nxt   = commit_ptr + PW'(1);
              drop_inc = 1'b1;
            end
            default: begin
              wr_nxt   = commit_ptr;
              st_nxt   = WR_DISCARD;
              drop_inc = 1'b1;
            end
          endcase
        end
        WR_DISCARD: begin
          unique case (1'b1)
            is_first: begin
              we     = 1'b1;
              wr_nxt = wr_ptr + PW'(1);
              st_nxt = WR_OPEN;
            end
            is_last: st_nxt = WR_IDLE;
            default: st_nxt = WR_DISCARD;
          endcase
        end
        default: st_nxt = WR_IDLE;
      endcase
      // a chunk that would be stored while full kills its message
      if (we && full) begin
        we        = 1'b0;
        wr_nxt    = commit_ptr;
        cm_nxt    = commit_ptr;
        commit_ev = 1'b0;
        drop_inc  = 1'b1;
        st_nxt    = is_last ? WR_IDLE : WR_DISCARD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      st         <= WR_IDLE;
      msg_count  <= '0;
      drop_count <= '0;
    end else begin
      wr_ptr     <= wr_nxt;
      commit_ptr <= cm_nxt;
      st         <= st_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({commit_ev, pop_last})
        2'b10:   msg_count <= msg_count + PW'(1);
        2'b01:   msg_count <= msg_count - PW'(1);
        default: msg_count <= msg_count;
      endcase
      if (drop_inc && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

  ipg_chunk_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(ipg_reply_chunk),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(tx_ipg_data)
  );

endmodule

// File: tb/tb_ipg_resp_tx_buf.sv
// Directed self-checking bench for ipg_resp_tx_buf.
module tb_ipg_resp_tx_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memq_write;
  logic [63:0] ipg_reply_chunk;
  logic        tx_ipg_ready;
  logic        tx_ipg_valid;
  logic [63:0] tx_ipg_data;
  logic [4:0]  msg_count;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] mon_q [$];

  always #5 clk = ~clk;

  ipg_resp_tx_buf dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memq_write     (memq_write),
    .ipg_reply_chunk(ipg_reply_chunk),
    .tx_ipg_ready   (tx_ipg_ready),
    .tx_ipg_valid   (tx_ipg_valid),
    .tx_ipg_data    (tx_ipg_data),
    .msg_count      (msg_count),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  always @(negedge clk) begin
    if (rst_n && tx_ipg_valid && tx_ipg_ready) begin
      mon_q.push_back(tx_ipg_data);
    end
  end

  function automatic logic [63:0] mk(input logic [7:0] t,
                                     input logic [55:0] p);
    return {p, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] t, input logic [55:0] p);
    memq_write      = 1'b1;
    ipg_reply_chunk = mk(t, p);
    step();
    memq_write      = 1'b0;
  endtask

  task automatic idle(input int n);
    memq_write = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_q(input string tag, input logic [63:0] exp [$]);
    chk({tag, "_len"}, 64'(mon_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
      chk($sformatf("%s_%0d", tag, i), mon_q[i], exp[i]);
    end
  endtask

  initial begin
    logic [63:0] exp_q [$];
    logic [4:0]  rdy_pat;
    logic [63:0] exp_d [5];

    rst_n           = 1'b0;
    memq_write      = 1'b0;
    ipg_reply_chunk = '0;
    tx_ipg_ready    = 1'b0;
    #12;
    chk("rst_valid", 64'(tx_ipg_valid), 64'd0);
    chk("rst_data", tx_ipg_data, 64'd0);
    chk("rst_msg", 64'(msg_count), 64'd0);
    chk("rst_lvl", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rst_n = 1'b1;
    step();

    // basic message, ready held high
    tx_ipg_ready = 1'b1;
    mon_q.delete();
    wr(8'h0b, 56'h1);
    chk("t1_v0", 64'(tx_ipg_valid), 64'd0);
    wr(8'h1b, 56'h2);
    chk("t1_v1", 64'(tx_ipg_valid), 64'd0);
    wr(8'h2b, 56'h3);
    chk("t1_v2", 64'(tx_ipg_valid), 64'd1);
    chk("t1_msg1", 64'(msg_count), 64'd1);
    chk("t1_d0", tx_ipg_data, mk(8'h0b, 56'h1));
    step();
    chk("t1_d1", tx_ipg_data, mk(8'h1b, 56'h2));
    step();
    chk("t1_d2", tx_ipg_data, mk(8'h2b, 56'h3));
    step();
    chk("t1_vend", 64'(tx_ipg_valid), 64'd0);
    chk("t1_msg0", 64'(msg_count), 64'd0);
    chk("t1_drop", 64'(drop_count), 64'd0);
    exp_q = '{mk(8'h0b, 56'h1), mk(8'h1b, 56'h2), mk(8'h2b, 56'h3)};
    chk_q("t1_q", exp_q);

    // stalls on the read side
    tx_ipg_ready = 1'b0;
    mon_q.delete();
    wr(8'h0b, 56'h11);
    wr(8'h1b, 56'h12);
    wr(8'h2b, 56'h13);
    rdy_pat  = 5'b11001;
    exp_d[0] = mk(8'h0b, 56'h11);
    exp_d[1] = mk(8'h1b, 56'h12);
    exp_d[2] = mk(8'h1b, 56'h12);
    exp_d[3] = mk(8'h1b, 56'h12);
    exp_d[4] = mk(8'h2b, 56'h13);
    for (int i = 0; i < 5; i++) begin
      tx_ipg_ready = rdy_pat[i];
      chk($sformatf("t2_d%0d", i), tx_ipg_data, exp_d[i]);
      step();
    end
    chk("t2_vend", 64'(tx_ipg_valid), 64'd0);
    exp_q = '{mk(8'h0b, 56'h11), mk(8'h1b, 56'h12), mk(8'h2b, 56'h13)};
    chk_q("t2_q", exp_q);

    // overflow: fifth message rolls back
    tx_ipg_ready = 1'b0;
    mon_q.delete();
    for (int m = 0; m < 5; m++) begin
      wr(8'h0b, 56'(m * 16 + 0));
      wr(8'h1b, 56'(m * 16 + 1));
      wr(8'h1b, 56'(m * 16 + 2));
      wr(8'h2b, 56'(m * 16 + 3));
    end
    chk("t3_lvl", 64'(fifo_level), 64'd16);
    chk("t3_msg", 64'(msg_count), 64'd4);
    chk("t3_drop", 64'(drop_count), 64'd1);
    tx_ipg_ready = 1'b1;
    idle(20);
    chk("t3_cnt", 64'(mon_q.size()), 64'd16);
    if (mon_q.size() == 16) begin
      chk("t3_first", mon_q[0], mk(8'h0b, 56'h0));
      chk("t3_last", mon_q[15], mk(8'h2b, 56'h33));
    end
    chk("t3_lvl0", 64'(fifo_level), 64'd0);
    chk("t3_msg0", 64'(msg_count), 64'd0);

    // malformed middle chunk
    mon_q.delete();
    wr(8'h0b, 56'h41);
    wr(8'h1b, 56'h42);
    wr(8'h5a, 56'h43);
    wr(8'h2b, 56'h44);
    wr(8'h0b, 56'h45);
    wr(8'h2b, 56'h46);
    idle(5);
    chk("t4_drop", 64'(drop_count), 64'd2);
    exp_q = '{mk(8'h0b, 56'h45), mk(8'h2b, 56'h46)};
    chk_q("t4_q", exp_q);

    // restart inside an open message
    mon_q.delete();
    wr(8'h0b, 56'h51);
    wr(8'h1b, 56'h52);
    wr(8'h0b, 56'h53);
    wr(8'h1b, 56'h54);
    wr(8'h2b, 56'h55);
    idle(5);
    chk("t5_drop", 64'(drop_count), 64'd3);
    exp_q = '{mk(8'h0b, 56'h53), mk(8'h1b, 56'h54), mk(8'h2b, 56'h55)};
    chk_q("t5_q", exp_q);

    // async reset mid-send
    tx_ipg_ready = 1'b0;
    wr(8'h0b, 56'h61);
    wr(8'h1b, 56'h62);
    wr(8'h2b, 56'h63);
    tx_ipg_ready = 1'b1;
    step();
    chk("t6_mid", tx_ipg_data, mk(8'h1b, 56'h62));
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(tx_ipg_valid), 64'd0);
    chk("t6_data", tx_ipg_data, 64'd0);
    chk("t6_msg", 64'(msg_count), 64'd0);
    chk("t6_lvl", 64'(fifo_level), 64'd0);
    chk("t6_drop", 64'(drop_count), 64'd0);
    idle(2);
    rst_n = 1'b1;
    step();
    mon_q.delete();
    wr(8'h0b, 56'h71);
    wr(8'h2b, 56'h72);
    idle(4);
    exp_q = '{mk(8'h0b, 56'h71), mk(8'h2b, 56'h72)};
    chk_q("t6_q", exp_q);
    chk("t6_msg0", 64'(msg_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ipg_resp_tx_buf.md
# ipg_resp_tx_buf

Store-and-forward buffer between the read-request processor's reply generator and the TX-side IPG inserter. It accepts 64-bit reply chunks on `memq_write` / `ipg_reply_chunk` and holds each response message until its last chunk arrives. It then offers whole messages, in order, to the TX IPG slot handshake. Partial messages that overflow the buffer or are malformed are rolled back and counted, so the TX side never sees a truncated response.

## Interface
- `DATA_WIDTH`, 64: chunk width. Block type is in bits [7:0].
- `DEPTH`, 16: buffer entries. Power of two, at least 8.
- `CNT_WIDTH`, 16: width of the drop counter. Saturating.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `memq_write`  in  1  chunk valid from the reply generator. There is no back-pressure.
- `ipg_reply_chunk`  in  DATA_WIDTH  reply chunk.
- `tx_ipg_ready`  in  1  TX IPG inserter can take a chunk this cycle.
- `tx_ipg_valid`  out  1  a committed chunk is available.
- `tx_ipg_data`  out  DATA_WIDTH  chunk at the read pointer.
- `msg_count`  out  $clog2(DEPTH)+1  committed, not fully sent messages.
- `fifo_level`  out  $clog2(DEPTH)+1  occupied entries, committed plus open.
- `drop_count`  out  CNT_WIDTH  discarded messages.

## Operation
- Block types: `RESPFIRST` = 8'h0b, `RRESP` = 8'h1b, `RESPLAST` = 8'h2b. A message is `0b` {`1b`}* `2b`, or a lone `2b`.
- Three pointers are kept: `wr_ptr`, `commit_ptr` and `rd_ptr`, each $clog2(DEPTH)+1 bits with a wrap bit.
- The read side sees only the range `rd_ptr`..`commit_ptr`.
- Write FSM states are IDLE, OPEN and DISCARD.
- **IDLE**
  - `0b`: write it, go to OPEN.
  - `2b`: write it and commit (`commit_ptr` ← `wr_ptr`+1).
  - `1b` or any other type: enter DISCARD and increment `drop_count`.
- **OPEN**
  - `1b`: write it.
  - `2b`: write it, commit, go to IDLE.
  - `0b`: roll back (`wr_ptr` ← `commit_ptr`), write this chunk at `commit_ptr`, stay in OPEN, increment `drop_count`.
  - Any other type: roll back, go to DISCARD, increment `drop_count`.
- **DISCARD**
  - Ignore every chunk up to and including the next `2b`, then go to IDLE.
  - A `0b` seen in DISCARD starts a new message: write it, go to OPEN, no extra count.
- Full condition: `wr_ptr` − `rd_ptr` == DEPTH, evaluated on registered state.
  - A write while full is a drop: roll back, increment `drop_count`, go to DISCARD.
  - If that chunk was `2b`, go to IDLE instead.
- Any message longer than DEPTH chunks is always dropped.
- Read side, show-ahead:
  - `tx_ipg_valid` = (`rd_ptr` != `commit_ptr`).
  - `tx_ipg_data` = mem[`rd_ptr`].
  - On `valid & ready`: `rd_ptr`++.
  - When the popped chunk is type `2b`, `msg_count` decrements.
- `msg_count` increments on commit. Increment and decrement in the same cycle leave it unchanged.
- `drop_count` saturates at all-ones.

## Timing
- Every chunk is registered into memory at the rising edge where `memq_write` = 1.
- Latency: the `2b` is written at edge N, and `tx_ipg_valid` rises in the cycle after edge N. Minimum in-to-out latency is 1 cycle.
- Throughput is one chunk per cycle on each side, concurrently.
- When `tx_ipg_valid` = 1 and `tx_ipg_ready` = 0, `tx_ipg_data` is held stable.
- Simultaneous pop and write while full: the write is still dropped. Full is judged before the pop.
- Simultaneous rollback and pop: the pop proceeds. Rollback never moves below `commit_ptr`, so `rd_ptr` is never crossed.
- Reset values:
  - All pointers 0, FSM in IDLE.
  - `tx_ipg_valid` 0, `tx_ipg_data` 0 (mem[0] is reset to 0).
  - `msg_count` 0, `fifo_level` 0, `drop_count` 0.
- Reset asserted mid-message or mid-send discards everything. Outputs go to reset values immediately (asynchronous).

## Structure
- Shared package `ipg_pkg` holds the block-type constants (`0a`/`1a`/`2a`, `0b`/`1b`/`2b`, `0c`/`1c`/`2c`) and the write FSM state encoding. Neighbouring IPG blocks reuse both.
- One sub-module, `ipg_chunk_ram`: a DEPTH×DATA_WIDTH simple dual-port register array with one write port and an asynchronous read port.
- The pointer logic, write FSM and counters stay in the top module.

## Test plan
- Write `0b`, `1b`, `2b` on consecutive cycles with ready=1.
  - No valid until the cycle after `2b` is written.
  - Three chunks then emit back-to-back.
  - `msg_count` goes 1→0 and `drop_count` stays 0.
- Same message with `tx_ipg_ready` toggling 1,0,0,1,1 → data is held stable across the stalls and all three chunks emit in order.
- Hold ready=0 and write five 4-chunk messages.
  - The first four commit: `fifo_level`=16, `msg_count`=4.
  - The fifth is rolled back: `drop_count`=1.
  - Then raise ready → exactly 16 chunks emit.
- Write `0b`, `1b`, then a chunk of type `5a`, then `2b`, then a clean 2-chunk message.
  - The first message never appears; `drop_count`=1.
  - Only the clean message emits.
- Write `0b`, `1b`, `0b`, `1b`, `2b` → only the last three chunks emit and `drop_count`=1.
- Assert `rst_n` low while the second chunk of a committed message is being sent → `tx_ipg_valid`=0 and all status outputs are 0 immediately. After release, a new message passes normally.
